ldl_fifo_rd_stream: RTL and testbench

- Read-side drain engine for the library FIFOs (sync and async read port).
- Pops words from a FIFO read interface (empty/re/dout) and presents them downstream as a registered valid/ready stream.
- Supports both show-ahead (AHEAD=1) and registered-output (AHEAD=0) FIFO read timing.
- Sustains one word per clock with no combinational path from m_ready to fifo_re.

---
 rtl/ldl_fifo_rd_stream.sv | 128 ++++++++++++
 tb/tb_ldl_fifo_rd_stream.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// ldl_fifo_rd_stream
//
// Read-side drain engine for the library FIFOs. Pops words from a FIFO read
// port (fifo_empty / fifo_re / fifo_dout) into a 3-entry in-order buffer and
// presents the head of that buffer as a registered valid/ready stream.
//
// Parameters
//   DW     data width
//   AHEAD  1: show-ahead FIFO, fifo_dout valid while ~fifo_empty
//          0: registered FIFO, fifo_dout valid the cycle after fifo_re
//
// Ports
//   clk         clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   flush       synchronous buffer flush (only with LDL_FIFO_RD_STREAM_FLUSH_EN)
//   fifo_empty  FIFO empty flag
//   fifo_re     FIFO pop, never depends on m_ready
//   fifo_dout   FIFO read data
//   m_valid     stream valid (registered: occ != 0)
//   m_ready     stream consumer ready
//   m_data      stream data (head buffer entry)
//   occ         words currently held in the buffer, 0..3
//
// Optional feature: define LDL_FIFO_RD_STREAM_FLUSH_EN to add the flush port.
// -----------------------------------------------------------------------------
module ldl_fifo_rd_stream #(
    parameter int DW    = 8,
    parameter bit AHEAD = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef LDL_FIFO_RD_STREAM_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          fifo_empty,
    output logic          fifo_re,
    input  logic [DW-1:0] fifo_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    occ
);

    logic [DW-1:0] buf_mem [3];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [1:0]    occ_q;
    logic          inflight;
    logic          flush_act;
    logic          capture;
    logic          pop;
    logic [2:0]    level;
    logic [1:0]    occ_next;

`ifdef LDL_FIFO_RD_STREAM_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Modulo-3 pointer advance.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already owned by this block: buffered plus the one still in
    // the FIFO output register (registered-output FIFOs only).
    assign level = {1'b0, occ_q} + {2'b00, inflight};

    // Pop decision uses only local state, so m_ready never reaches fifo_re.
    // Gating with rst_n keeps the FIFO untouched while reset is held.
    assign fifo_re = rst_n & ~fifo_empty & ~flush_act & (level < 3'd3);

    // Show-ahead data is taken in the pop cycle; registered data one later.
    assign capture = (AHEAD ? fifo_re : inflight) & ~flush_act;
    assign pop     = m_valid & m_ready;

    // Capture only happens with room left, pop only with occ != 0: no wrap.
    assign occ_next = occ_q + {1'b0, capture} - {1'b0, pop};

    // ---- buffer / pointer register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            occ_q    <= 2'd0;
            inflight <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (flush_act) begin
            // The word owed by an inflight pop is dropped along with the buffer.
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            occ_q    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (capture && (wr_ptr == 2'(i))) begin
                    buf_mem[i] <= fifo_dout;
                end
            end
            if (capture) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ_q    <= occ_next;
            inflight <= AHEAD ? 1'b0 : fifo_re;
        end
    end

    // Head entry select; pointer never reaches 3.
    always_comb begin
        m_data = buf_mem[2];
        case (rd_ptr)
            2'd0:    m_data = buf_mem[0];
            2'd1:    m_data = buf_mem[1];
            default: m_data = buf_mem[2];
        endcase
    end

    assign m_valid = (occ_q != 2'd0);
    assign occ     = occ_q;

endmodule

// File: tb/tb_ldl_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_ldl_fifo_rd_stream
//
// Runs an AHEAD=0 instance (index 0) and an AHEAD=1 instance (index 1) side by
// side, each fed by its own FIFO model. Directed vectors plus a scoreboard on
// every stream transfer.
// -----------------------------------------------------------------------------
module tb_ldl_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       e0, e1, re0, re1, mv0, mv1, mr0, mr1;
    logic [7:0] din0, din1, md0, md1;
    logic [1:0] occ0, occ1;
    logic [1:0] hold_e;
    logic [1:0] fifo_clear;
`ifdef LDL_FIFO_RD_STREAM_FLUSH_EN
    logic       fl0, fl1;
`endif

    logic [7:0] fmem [2][0:2047];
    int         fwr [2];
    int         sb_idx [2];
    int         re_cnt [2];
    int         frd0 = 0;
    int         frd1 = 0;
    logic [7:0] dreg0 = 8'h00;
    logic       infl0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    ldl_fifo_rd_stream #(.DW(8), .AHEAD(1'b0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef LDL_FIFO_RD_STREAM_FLUSH_EN
        .flush      (fl0),
`endif
        .fifo_empty (e0),
        .fifo_re    (re0),
        .fifo_dout  (din0),
        .m_valid    (mv0),
        .m_ready    (mr0),
        .m_data     (md0),
        .occ        (occ0)
    );

    ldl_fifo_rd_stream #(.DW(8), .AHEAD(1'b1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef LDL_FIFO_RD_STREAM_FLUSH_EN
        .flush      (fl1),
`endif
        .fifo_empty (e1),
        .fifo_re    (re1),
        .fifo_dout  (din1),
        .m_valid    (mv1),
        .m_ready    (mr1),
        .m_data     (md1),
        .occ        (occ1)
    );

    // FIFO models: index 0 registered output, index 1 show-ahead.
    assign e0   = (frd0 == fwr[0]) || hold_e[0];
    assign e1   = (frd1 == fwr[1]) || hold_e[1];
    assign din0 = dreg0;
    assign din1 = fmem[1][frd1];

    always @(posedge clk) begin
        if (fifo_clear[0]) begin
            frd0 <= fwr[0];
        end else if (re0) begin
            frd0  <= frd0 + 1;
            dreg0 <= fmem[0][frd0];
        end
    end

    always @(posedge clk) begin
        if (fifo_clear[1]) begin
            frd1 <= fwr[1];
        end else if (re1) begin
            frd1 <= frd1 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [7:0] val);
        fmem[d][fwr[d]] = val;
        fwr[d]++;
    endtask

    // Settle, then score any transfer the coming edge will perform.
    task automatic sample();
        #1;
        if (mv0 && mr0) begin
            check("sb_data0", {24'h0, md0}, {24'h0, fmem[0][sb_idx[0]]});
            sb_idx[0]++;
        end
        if (mv1 && mr1) begin
            check("sb_data1", {24'h0, md1}, {24'h0, fmem[1][sb_idx[1]]});
            sb_idx[1]++;
        end
        if (re0) re_cnt[0]++;
        if (re1) re_cnt[1]++;
        check("level0", 32'({1'b0, occ0} + {2'b00, infl0} <= 3'd3), 32'd1);
        check("level1", 32'(occ1 <= 2'd3), 32'd1);
        infl0 = re0;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    initial begin
        int base0, base1, cyc;
        rst_n      = 1'b0;
        mr0        = 1'b0;
        mr1        = 1'b0;
        hold_e     = 2'b00;
        fifo_clear = 2'b00;
        infl0      = 1'b0;
`ifdef LDL_FIFO_RD_STREAM_FLUSH_EN
        fl0 = 1'b0;
        fl1 = 1'b0;
`endif
        for (int d = 0; d < 2; d++) begin
            fwr[d]    = 0;
            sb_idx[d] = 0;
            re_cnt[d] = 0;
        end

        // Reset state
        #12;
        check("rst_occ0", 32'(occ0), 32'd0);
        check("rst_occ1", 32'(occ1), 32'd0);
        check("rst_mv0", 32'(mv0), 32'd0);
        check("rst_mv1", 32'(mv1), 32'd0);
        check("rst_md0", 32'(md0), 32'd0);
        check("rst_md1", 32'(md1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        advance();

        // Streaming 0xA1..0xA5 with m_ready high
        mr0 = 1'b1;
        mr1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(0, 8'hA1 + 8'(i));
            push(1, 8'hA1 + 8'(i));
        end
        for (int k = 0; k < 8; k++) begin
            sample();
            check("s_re1", 32'(re1), 32'(k < 5));
            check("s_re0", 32'(re0), 32'(k < 5));
            check("s_mv1", 32'(mv1), 32'((k >= 1) && (k <= 5)));
            check("s_mv0", 32'(mv0), 32'((k >= 2) && (k <= 6)));
            if ((k >= 1) && (k <= 5)) check("s_md1", 32'(md1), 32'(8'hA1 + 8'(k - 1)));
            if ((k >= 2) && (k <= 6)) check("s_md0", 32'(md0), 32'(8'hA1 + 8'(k - 2)));
            advance();
        end

        // Backpressure: 6 words, consumer stalled
        mr0 = 1'b0;
        mr1 = 1'b0;
        base0 = sb_idx[0];
        base1 = sb_idx[1];
        re_cnt[0] = 0;
        re_cnt[1] = 0;
        for (int i = 0; i < 6; i++) begin
            push(0, 8'hA1 + 8'(i));
            push(1, 8'hA1 + 8'(i));
        end
        run(8);
        check("bp_re_cnt0", 32'(re_cnt[0]), 32'd3);
        check("bp_re_cnt1", 32'(re_cnt[1]), 32'd3);
        check("bp_occ0", 32'(occ0), 32'd3);
        check("bp_occ1", 32'(occ1), 32'd3);
        check("bp_md0", 32'(md0), 32'hA1);
        check("bp_md1", 32'(md1), 32'hA1);
        check("bp_re_full1", 32'(re1), 32'd0);
        mr0 = 1'b1;
        mr1 = 1'b1;
        run(12);
        check("bp_drain0", 32'(sb_idx[0] - base0), 32'd6);
        check("bp_drain1", 32'(sb_idx[1] - base1), 32'd6);
        check("bp_occ_end0", 32'(occ0), 32'd0);

        // Random empty / ready, 1000 words per instance
        base0 = sb_idx[0] + 1000;
        base1 = sb_idx[1] + 1000;
        cyc = 0;
        while (((sb_idx[0] < base0) || (sb_idx[1] < base1)) && (cyc < 20000)) begin
            while ((fwr[0] - frd0 < 4) && (fwr[0] < base0)) push(0, 8'($urandom));
            while ((fwr[1] - frd1 < 4) && (fwr[1] < base1)) push(1, 8'($urandom));
            hold_e = 2'($urandom_range(0, 3));
            mr0    = 1'($urandom_range(0, 1));
            mr1    = 1'($urandom_range(0, 1));
            sample();
            advance();
            cyc++;
        end
        check("rand_done0", 32'(sb_idx[0]), 32'(base0));
        check("rand_done1", 32'(sb_idx[1]), 32'(base1));
        hold_e = 2'b00;

        // Asynchronous reset mid-burst
        mr0 = 1'b0;
        mr1 = 1'b0;
        run(2);
        for (int i = 0; i < 4; i++) begin
            push(0, 8'h50 + 8'(i));
            push(1, 8'h50 + 8'(i));
        end
        run(2);
        check("pre_rst_occ1", 32'(occ1), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mv0", 32'(mv0), 32'd0);
        check("arst_mv1", 32'(mv1), 32'd0);
        check("arst_occ0", 32'(occ0), 32'd0);
        check("arst_occ1", 32'(occ1), 32'd0);
        check("arst_re0", 32'(re0), 32'd0);
        check("arst_re1", 32'(re1), 32'd0);
        fifo_clear = 2'b11;
        advance();
        fifo_clear = 2'b00;
        infl0      = 1'b0;
        sb_idx[0]  = fwr[0];
        sb_idx[1]  = fwr[1];
        base0      = fwr[0];
        base1      = fwr[1];
        for (int i = 0; i < 4; i++) begin
            push(0, 8'hC0 + 8'(i));
            push(1, 8'hC0 + 8'(i));
        end
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        run(4);
        check("post_rst_mv0", 32'(mv0), 32'd1);
        check("post_rst_md0", 32'(md0), 32'hC0);
        check("post_rst_md1", 32'(md1), 32'hC0);
        mr0 = 1'b1;
        mr1 = 1'b1;
        run(8);
        check("post_rst_drain0", 32'(sb_idx[0] - base0), 32'd4);
        check("post_rst_drain1", 32'(sb_idx[1] - base1), 32'd4);

`ifdef LDL_FIFO_RD_STREAM_FLUSH_EN
        // Flush with occ=2 and one word inflight on the registered instance
        mr0   = 1'b0;
        base0 = fwr[0];
        for (int i = 0; i < 6; i++) push(0, 8'hD0 + 8'(i));
        run(3);
        check("fl_pre_occ0", 32'(occ0), 32'd2);
        fl0 = 1'b1;
        #1;
        check("fl_re0", 32'(re0), 32'd0);
        sample();
        advance();
        fl0 = 1'b0;
        check("fl_occ0", 32'(occ0), 32'd0);
        check("fl_mv0", 32'(mv0), 32'd0);
        sb_idx[0] = base0 + 3;
        run(4);
        check("fl_next_md0", 32'(md0), 32'hD3);
        mr0 = 1'b1;
        run(8);
        check("fl_drain0", 32'(sb_idx[0] - base0), 32'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
